// File: rtl/ttt_pkg.sv
// Shared tic-tac-toe definitions: cell/winner codes, winning-line table and scan states.
// Imported by game_board, its line_checker and the game controller.
package ttt_pkg;

  typedef enum logic [1:0] {
    CELL_EMPTY = 2'b00,
    CELL_P2    = 2'b10,
    CELL_P1    = 2'b11
  } cell_t;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_TIE  = 2'b01,
    WIN_P2   = 2'b10,
    WIN_P1   = 2'b11
  } winner_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } scanState_t;

  localparam int         NUM_CELLS = 9;
  localparam int         NUM_LINES = 8;
  localparam int         BOARD_W   = 2 * NUM_CELLS;
  localparam logic [3:0] MAX_MOVES = 4'd9;
  localparam logic [3:0] MAX_ADDR  = 4'd8;

  // Cell indices of each winning line, packed {first, second, third}; rows, columns, diagonals.
  function automatic logic [11:0] lineTable(input logic [2:0] line);
    case (line)
      3'd0:    return {4'd0, 4'd1, 4'd2};
      3'd1:    return {4'd3, 4'd4, 4'd5};
      3'd2:    return {4'd6, 4'd7, 4'd8};
      3'd3:    return {4'd0, 4'd3, 4'd6};
      3'd4:    return {4'd1, 4'd4, 4'd7};
      3'd5:    return {4'd2, 4'd5, 4'd8};
      3'd6:    return {4'd0, 4'd4, 4'd8};
      default: return {4'd2, 4'd4, 4'd6};
    endcase
  endfunction

  function automatic logic [1:0] cellAt(input logic [BOARD_W-1:0] board, input logic [3:0] idx);
    return board[{idx, 1'b0} +: 2];
  endfunction

endpackage

// File: rtl/game_board_if.sv
// Controller <-> board-responder bus: new-game clear, cell writes, and board/result feedback.
interface game_board_if;

  logic        clear;
  logic        wrEn;
  logic [3:0]  addr;
  logic [1:0]  cellState;
  logic [17:0] gBoard;
  logic        gameIsDone;
  logic [1:0]  winner;
  logic        busy;
  logic        wrAck;
  logic        wrErr;

  modport master (
    output clear, wrEn, addr, cellState,
    input  gBoard, gameIsDone, winner, busy, wrAck, wrErr
  );

  modport slave (
    input  clear, wrEn, addr, cellState,
    output gBoard, gameIsDone, winner, busy, wrAck, wrErr
  );

endinterface

// File: rtl/game_board_line_checker.sv
// Combinational check of one winning line: three equal, non-empty cells form a match.
module line_checker
  import ttt_pkg::*;
(
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic [1:0] c,
  output logic       match,
  output logic [1:0] mark
);

  assign match = (a != CELL_EMPTY) && (a == b) && (b == c);
  assign mark  = a;

endmodule

// File: rtl/game_board.sv
// Tic-tac-toe board responder: validates/stores cell writes, then scans the eight lines.
// GAME_BOARD_PARALLEL_CHECK_EN selects a one-cycle parallel check instead of the 8-cycle scan.
module game_board
  import ttt_pkg::*;
(
  input  logic         ph1,
  input  logic         reset,
  game_board_if.slave  bus
);

  scanState_t         state, nextState;
  logic [BOARD_W-1:0] board;
  logic [3:0]         moveCount;
  winner_t            winnerReg, scanWin, result;
  logic               wrAckReg, wrErrReg, busyInt, doneInt;
  logic               addrOk, dataOk, cellFree, accept;
  logic [3:0]         addrSafe;
  logic               lineMatch, lastLine;
  logic [1:0]         lineMark;

  assign addrOk   = (bus.addr <= MAX_ADDR);
  assign addrSafe = addrOk ? bus.addr : 4'd0;
  assign dataOk   = (bus.cellState == CELL_P1) || (bus.cellState == CELL_P2);
  assign cellFree = (cellAt(board, addrSafe) == CELL_EMPTY);
  assign accept   = bus.wrEn && !bus.clear && addrOk && dataOk && cellFree && (state == IDLE);

`ifdef GAME_BOARD_PARALLEL_CHECK_EN
  logic [NUM_LINES-1:0]      allMatch;
  logic [NUM_LINES-1:0][1:0] allMark;

  for (genvar g = 0; g < NUM_LINES; g++) begin : gLine
    logic [11:0] cells;
    assign cells = lineTable(3'(g));
    line_checker uCheck (
      .a     (cellAt(board, cells[11:8])),
      .b     (cellAt(board, cells[7:4])),
      .c     (cellAt(board, cells[3:0])),
      .match (allMatch[g]),
      .mark  (allMark[g])
    );
  end

  // Lowest-numbered matching line wins, mirroring the order of the sequential scan.
  always_comb begin
    lineMatch = 1'b0;
    lineMark  = 2'b00;
    for (int i = NUM_LINES - 1; i >= 0; i--) begin
      if (allMatch[i]) begin
        lineMatch = 1'b1;
        lineMark  = allMark[i];
      end
    end
  end

  assign lastLine = 1'b1;
  assign scanWin  = lineMatch ? winner_t'(lineMark) : WIN_NONE;
`else
  logic [2:0]  lineCnt;
  logic [11:0] cells;
  winner_t     pending;

  assign cells = lineTable(lineCnt);

  line_checker uCheck (
    .a     (cellAt(board, cells[11:8])),
    .b     (cellAt(board, cells[7:4])),
    .c     (cellAt(board, cells[3:0])),
    .match (lineMatch),
    .mark  (lineMark)
  );

  always_ff @(posedge ph1 or posedge reset) begin
    if (reset) begin
      lineCnt <= 3'd0;
      pending <= WIN_NONE;
    end else if (bus.clear || state != SCAN) begin
      lineCnt <= 3'd0;
      pending <= WIN_NONE;
    end else begin
      lineCnt <= lineCnt + 3'd1;
      if (pending == WIN_NONE && lineMatch)
        pending <= winner_t'(lineMark);
    end
  end

  assign lastLine = (lineCnt == 3'd7);
  assign scanWin  = (pending != WIN_NONE) ? pending :
                    (lineMatch ? winner_t'(lineMark) : WIN_NONE);
`endif

  // A win takes precedence over a full board.
  always_comb begin
    result = WIN_NONE;
    if (scanWin != WIN_NONE)
      result = scanWin;
    else if (moveCount == MAX_MOVES)
      result = WIN_TIE;
  end

  always_ff @(posedge ph1 or posedge reset) begin
    if (reset)
      state <= IDLE;
    else if (bus.clear)
      state <= IDLE;
    else
      state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (accept) nextState = SCAN;
      SCAN:    if (lastLine) nextState = (result != WIN_NONE) ? DONE : IDLE;
      DONE:    nextState = DONE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    busyInt = (state == SCAN);
    doneInt = (state == DONE);
  end

  always_ff @(posedge ph1 or posedge reset) begin
    if (reset) begin
      board     <= '0;
      moveCount <= 4'd0;
      winnerReg <= WIN_NONE;
      wrAckReg  <= 1'b0;
      wrErrReg  <= 1'b0;
    end else if (bus.clear) begin
      board     <= '0;
      moveCount <= 4'd0;
      winnerReg <= WIN_NONE;
      wrAckReg  <= 1'b0;
      wrErrReg  <= 1'b0;
    end else begin
      wrAckReg <= accept;
      wrErrReg <= bus.wrEn && !accept;
      if (accept) begin
        board[{addrSafe, 1'b0} +: 2] <= bus.cellState;
        if (moveCount != MAX_MOVES)
          moveCount <= moveCount + 4'd1;
      end
      if (state == SCAN && lastLine && result != WIN_NONE)
        winnerReg <= result;
    end
  end

  assign bus.gBoard     = board;
  assign bus.gameIsDone = doneInt;
  assign bus.winner     = winnerReg;
  assign bus.busy       = busyInt;
  assign bus.wrAck      = wrAckReg;
  assign bus.wrErr      = wrErrReg;

endmodule

// File: tb/tb_game_board.sv
// Directed self-checking bench for game_board; honours GAME_BOARD_PARALLEL_CHECK_EN for result latency.
module tb_game_board;

`ifdef GAME_BOARD_PARALLEL_CHECK_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 9;
`endif

  logic        ph1;
  logic        reset;
  logic [17:0] expBoard;
  int          checks;
  int          errors;

  game_board_if bus ();

  game_board dut (
    .ph1   (ph1),
    .reset (reset),
    .bus   (bus)
  );

  initial ph1 = 1'b0;
  always #5 ph1 = ~ph1;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge ph1);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of controller signals, then return to an idle bus one cycle later.
  task automatic applyStimulus(input logic clr, input logic en, input logic [3:0] a, input logic [1:0] cs);
    bus.clear     = clr;
    bus.wrEn      = en;
    bus.addr      = a;
    bus.cellState = cs;
    tick();
    bus.clear     = 1'b0;
    bus.wrEn      = 1'b0;
    bus.addr      = 4'd0;
    bus.cellState = 2'b00;
  endtask

  task automatic clearBoard();
    applyStimulus(1'b1, 1'b0, 4'd0, 2'b00);
    expBoard = '0;
    checkOutput("clear_board", bus.gBoard, expBoard);
    checkOutput("clear_done", bus.gameIsDone, 0);
  endtask

  // Legal move; returns in cycle N+LAT, where the result becomes valid.
  task automatic doMove(input logic [3:0] a, input logic [1:0] cs);
    applyStimulus(1'b0, 1'b1, a, cs);
    expBoard[{a, 1'b0} +: 2] = cs;
    checkOutput("move_ack", bus.wrAck, 1);
    checkOutput("move_err", bus.wrErr, 0);
    checkOutput("move_busy_start", bus.busy, 1);
    checkOutput("move_board", bus.gBoard, expBoard);
    repeat (LAT - 2) tick();
    checkOutput("move_busy_end", bus.busy, 1);
    checkOutput("move_done_early", bus.gameIsDone, 0);
    tick();
    checkOutput("move_busy_idle", bus.busy, 0);
  endtask

  task automatic doReject(input string tag, input logic [3:0] a, input logic [1:0] cs);
    applyStimulus(1'b0, 1'b1, a, cs);
    checkOutput({tag, "_err"}, bus.wrErr, 1);
    checkOutput({tag, "_ack"}, bus.wrAck, 0);
    checkOutput({tag, "_board"}, bus.gBoard, expBoard);
    tick();
    checkOutput({tag, "_pulse"}, bus.wrErr, 0);
  endtask

  logic [1:0] tieCells [9];

  initial begin
    checks        = 0;
    errors        = 0;
    expBoard      = '0;
    reset         = 1'b1;
    bus.clear     = 1'b0;
    bus.wrEn      = 1'b0;
    bus.addr      = 4'd0;
    bus.cellState = 2'b00;
    tieCells      = '{2'b11, 2'b10, 2'b11, 2'b11, 2'b10, 2'b10, 2'b10, 2'b11, 2'b11};

    // Reset state
    repeat (2) tick();
    checkOutput("rst_board", bus.gBoard, 0);
    checkOutput("rst_done", bus.gameIsDone, 0);
    checkOutput("rst_winner", bus.winner, 0);
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_ack", bus.wrAck, 0);
    checkOutput("rst_err", bus.wrErr, 0);
    reset = 1'b0;
    tick();

    // Illegal writes on a board holding P1 in cell 4
    clearBoard();
    doMove(4'd4, 2'b11);
    checkOutput("one_move_done", bus.gameIsDone, 0);
    doReject("occupied", 4'd4, 2'b10);
    doReject("addr12", 4'd12, 2'b11);
    doReject("empty_data", 4'd3, 2'b00);

`ifndef GAME_BOARD_PARALLEL_CHECK_EN
    // Write while busy: rejected, scan of the earlier write still completes
    applyStimulus(1'b0, 1'b1, 4'd0, 2'b10);
    expBoard[1:0] = 2'b10;
    checkOutput("bw_ack", bus.wrAck, 1);
    repeat (2) tick();
    applyStimulus(1'b0, 1'b1, 4'd8, 2'b11);
    checkOutput("bw_err", bus.wrErr, 1);
    checkOutput("bw_busy", bus.busy, 1);
    repeat (5) tick();
    checkOutput("bw_scan_end", bus.busy, 0);
    checkOutput("bw_done", bus.gameIsDone, 0);
    checkOutput("bw_board", bus.gBoard, expBoard);
`endif

    // Row 0 win by P1
    clearBoard();
    doMove(4'd0, 2'b11);
    doMove(4'd1, 2'b11);
    doMove(4'd2, 2'b11);
    checkOutput("row_done", bus.gameIsDone, 1);
    checkOutput("row_winner", bus.winner, 2'b11);
    checkOutput("row_board", bus.gBoard, 18'h0003F);
    doReject("after_win", 4'd5, 2'b10);
    repeat (3) tick();
    checkOutput("row_winner_held", bus.winner, 2'b11);

    // Full board, no line: tie
    clearBoard();
    for (int i = 0; i < 9; i++) begin
      doMove(4'(i), tieCells[i]);
      if (i < 8)
        checkOutput("tie_not_done", bus.gameIsDone, 0);
    end
    checkOutput("tie_done", bus.gameIsDone, 1);
    checkOutput("tie_winner", bus.winner, 2'b01);
    doReject("tenth_write", 4'd0, 2'b11);

    // Asynchronous reset mid-scan
    clearBoard();
    applyStimulus(1'b0, 1'b1, 4'd3, 2'b11);
    tick();
    checkOutput("ar_busy_before", bus.busy, 1);
    #2 reset = 1'b1;
    #1;
    checkOutput("ar_board", bus.gBoard, 0);
    checkOutput("ar_busy", bus.busy, 0);
    checkOutput("ar_ack", bus.wrAck, 0);
    checkOutput("ar_winner", bus.winner, 0);
    #1 reset = 1'b0;
    expBoard = '0;
    tick();

    // Clear together with wrEn, mid-scan and on an idle board
    applyStimulus(1'b0, 1'b1, 4'd0, 2'b11);
    applyStimulus(1'b1, 1'b1, 4'd1, 2'b11);
    checkOutput("cw_board", bus.gBoard, 0);
    checkOutput("cw_busy", bus.busy, 0);
    checkOutput("cw_err", bus.wrErr, 0);
    checkOutput("cw_ack", bus.wrAck, 0);
    applyStimulus(1'b1, 1'b1, 4'd2, 2'b10);
    checkOutput("cw_idle_board", bus.gBoard, 0);
    checkOutput("cw_idle_err", bus.wrErr, 0);
    tick();

    // Anti-diagonal win by P2
    clearBoard();
    doMove(4'd2, 2'b10);
    doMove(4'd4, 2'b10);
    doMove(4'd6, 2'b10);
    checkOutput("diag_done", bus.gameIsDone, 1);
    checkOutput("diag_winner", bus.winner, 2'b10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
